decode_issue: RTL
=================

# decode_issue

Parametrised decode/issue stage replacing the fixed single-bypass decode. It sits between fetch and execute and accepts one instruction per cycle over a valid/ready handshake. It reads both register banks (integer `0xxxxx`, float `1xxxxx`) and resolves RAW/WAW hazards with a per-register busy scoreboard and NFWD prioritised bypass ports. It registers the decoded bundle for execute and holds it until execute accepts it.

## Interface
- `XLEN`, 32, operand width
- `PCW`, 27, pc width
- `NFWD`, 2, bypass port count; port 0 is the youngest producer
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low (`rst==0` resets on the clk edge)
- `in_valid` / `in_ready`  in/out  1  fetch handshake
- `inst`  in  32; `pc`  in  PCW
- `rf_rs1`, `rf_rs2`  out  6  register file read addresses (combinational from `inst`)
- `rf_rs1data`, `rf_rs2data`  in  XLEN  asynchronous register file read data
- `fwd_valid`  in  NFWD; `fwd_rd`  in  7*NFWD; `fwd_data`  in  XLEN*NFWD
- `wb_valid`  in  1; `wb_rd`  in  7; `wb_data`  in  XLEN  writeback; clears busy
- `flush`  in  1  discard held bundle
- `out_valid` / `out_ready`  out/in  1  execute handshake
- `dec_op1`, `dec_op2`  out  XLEN; `aluctl`  out  7; `dec_rd`  out  7; `dec_mre`, `dec_mwe`  out  1; `dec_branch`  out  7; `dec_pc`  out  PCW; `daddr`  out  30

## Operation
- Fields:
  - `op=inst[2:0]`, `funct=inst[5:3]`.
  - `rs1={fromf,inst[31:27]}`, `rs2={fromf,inst[10:6]}`, with `fromf = op==010 | {funct[2],op}==0011`.
  - rd = `{op[2:1]!=11, tof, inst[26:22]}`, with `tof = op==010 | {funct[2],op}==1011`.
  - immIL = sext(`inst[21:6]`).
- rs2 is a source when op ∈ {000,001,010,011,110}. rs1 is always a source.
- A register with index bits [4:0]==0 is never busy and never forwarded.
- Operand select, in priority order:
  1. Lowest-index port with `fwd_valid[i] & fwd_rd[i][6] & fwd_rd[i][5:0]==rs`.
  2. Then wb (`wb_valid & wb_rd[6] & wb_rd[5:0]==rs`).
  3. Then rf data.
- `op2` is immIL for op ∈ {100,101,111}.
- `daddr` = (selected rs1 + immIL)[29:0]; wrap-around is ignored.
- Hazard exists if any of:
  - a used source is busy and matches neither a fwd port nor wb;
  - the instruction writes rd (valid bit set, [4:0]≠0) and rd is busy (WAW).
- Issue = `in_valid & ~hazard & (~out_valid | out_ready) & ~flush`.
- `in_ready` = issue condition without the `in_valid` term.
- On issue, the output register loads the bundle:
  - `aluctl={inst[11],op,funct}`;
  - `dec_mwe = op==110 & funct[2:1]==11`;
  - `dec_mre = op==101 & funct[2:1]==00`;
  - `dec_branch[5:0]` = one-hot funct 0..5;
  - `dec_branch[6] = op==110 & ~&funct[2:1]`.
  - `out_valid` is set to 1.
- If `out_valid & out_ready` and there is no issue, `out_valid` is cleared to 0.
- Scoreboard is a 64-bit busy vector:
  - Set on issue for the written rd.
  - Cleared on `wb_valid` for `wb_rd`.
  - If set and clear hit the same register in one cycle, set wins.
- On flush, `out_valid` is cleared to 0. If the held bundle has a valid rd, its busy bit is also cleared. No issue occurs that cycle.

## Timing
- Reset values:
  - `out_valid=0`, `busy=0`;
  - all `dec_*`, `aluctl`, and `daddr` = 0;
  - `in_ready=0` during reset.
- Latency: an instruction accepted at edge N appears at the outputs after edge N, with `out_valid=1`.
- Full throughput: one issue per cycle when `out_ready=1` and there are no hazards.
- Outputs are held stable while `out_valid & ~out_ready`.
- Priority: `rst` > `flush` > issue/drain.
- If reset is asserted mid-stall, all state is cleared and the pending instruction is dropped.
- `in_ready` may depend combinationally on `out_ready`, fwd, and wb inputs.

## Configuration
- `DECODE_BYPASS_EN` defined: the fwd ports participate in operand select and in hazard resolution as described.
- `DECODE_BYPASS_EN` undefined:
  - the fwd ports are ignored (inputs unused);
  - only the wb port forwards;
  - any busy source stalls until its `wb_valid` cycle.

## Test plan
- Reset with `rst=0` for 2 cycles, then `in_valid=1` with `add x3,x1,x2`. Required: `out_valid=1` one cycle later, `dec_rd=7'b1000011`, busy[3]=1.
- Producer `x3` busy, then a consumer of `x3` with `fwd_valid[1]=1`, `fwd_rd[1]=7'h43`, `fwd_data[1]=32'h1234`, and port 0 also matching with `32'hABCD`. Required: `dec_op1=32'hABCD` with the macro defined. With the macro undefined: `in_ready=0` until `wb_valid` for `x3`, then `dec_op1=wb_data`.
- WAW: two back-to-back writers of `f5` (`op=010`). Required: the second is held with `in_ready=0` until wb clears busy[37], then issues.
- Same-cycle set/clear: issue a writer of x7 while `wb_valid=1`, `wb_rd=7'h47`. Required: busy[7]=1 afterwards.
- Backpressure and flush:
  - hold `out_ready=0` for 3 cycles; required: outputs stable and `in_ready=0`;
  - then assert `flush`; required: `out_valid=0` and the held rd's busy bit cleared.
- Load, store, and branch:
  - `lw` (`op=101`, `funct=000`, rs1 data 32'h100, imm=-4). Required: `daddr=30'h0FC`, `dec_mre=1`.
  - beq (`op=110`, `funct=000`). Required: `dec_branch=7'b1000001`, `dec_rd[6]=0`, busy unchanged.

Source files
------------

// File: rtl/decode_issue.sv
// ============================================================================
// Module      : decode_issue
// Description : Decode/issue stage with busy scoreboard and prioritised bypass.
//               Optional macro DECODE_BYPASS_EN enables the fwd bypass ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_issue #(
    parameter int XLEN = 32,
    parameter int PCW  = 27,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          inst,
    input  logic [PCW-1:0]       pc,
    output logic [5:0]           rf_rs1,
    output logic [5:0]           rf_rs2,
    input  logic [XLEN-1:0]      rf_rs1data,
    input  logic [XLEN-1:0]      rf_rs2data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [7*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 wb_valid,
    input  logic [6:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      dec_op1,
    output logic [XLEN-1:0]      dec_op2,
    output logic [6:0]           aluctl,
    output logic [6:0]           dec_rd,
    output logic                 dec_mre,
    output logic                 dec_mwe,
    output logic [6:0]           dec_branch,
    output logic [PCW-1:0]       dec_pc,
    output logic [29:0]          daddr
);

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [2:0]      w_op;
    logic [2:0]      w_funct;
    logic            w_fromf;
    logic            w_tof;
    logic [5:0]      w_rs1;
    logic [5:0]      w_rs2;
    logic [6:0]      w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_rs1_nz;
    logic            w_rs2_nz;
    logic            w_rd_wr;
    logic            w_rs2_used;
    logic            w_op2_imm;

    assign w_op       = inst[2:0];
    assign w_funct    = inst[5:3];
    assign w_fromf    = (w_op == 3'b010) | ({w_funct[2], w_op} == 4'b0011);
    assign w_tof      = (w_op == 3'b010) | ({w_funct[2], w_op} == 4'b1011);
    assign w_rs1      = {w_fromf, inst[31:27]};
    assign w_rs2      = {w_fromf, inst[10:6]};
    assign w_rd       = {(w_op[2:1] != 2'b11), w_tof, inst[26:22]};
    assign w_imm      = {{(XLEN-16){inst[21]}}, inst[21:6]};
    assign w_rs1_nz   = (w_rs1[4:0] != 5'd0);
    assign w_rs2_nz   = (w_rs2[4:0] != 5'd0);
    assign w_rd_wr    = w_rd[6] & (w_rd[4:0] != 5'd0);
    assign w_rs2_used = (w_op == 3'b000) | (w_op == 3'b001) | (w_op == 3'b010) |
                        (w_op == 3'b011) | (w_op == 3'b110);
    assign w_op2_imm  = (w_op == 3'b100) | (w_op == 3'b101) | (w_op == 3'b111);

    assign rf_rs1 = w_rs1;
    assign rf_rs2 = w_rs2;

    // ------------------------------------------------------------------
    // Bypass network
    // ------------------------------------------------------------------
    logic [NFWD-1:0] w_rs1_match;
    logic [NFWD-1:0] w_rs2_match;
    logic [XLEN-1:0] w_rs1_fwd_data;
    logic [XLEN-1:0] w_rs2_fwd_data;

`ifdef DECODE_BYPASS_EN
    generate
        for (genvar gi = 0; gi < NFWD; gi++) begin : g_fwd_match
            assign w_rs1_match[gi] = fwd_valid[gi] & fwd_rd[7*gi+6] &
                                     (fwd_rd[7*gi +: 6] == w_rs1) & w_rs1_nz;
            assign w_rs2_match[gi] = fwd_valid[gi] & fwd_rd[7*gi+6] &
                                     (fwd_rd[7*gi +: 6] == w_rs2) & w_rs2_nz;
        end
    endgenerate

    // Walk from the oldest port down so the youngest matching port wins.
    always_comb begin
        w_rs1_fwd_data = '0;
        w_rs2_fwd_data = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (w_rs1_match[i]) w_rs1_fwd_data = fwd_data[XLEN*i +: XLEN];
            if (w_rs2_match[i]) w_rs2_fwd_data = fwd_data[XLEN*i +: XLEN];
        end
    end
`else
    logic w_unused_fwd;

    assign w_rs1_match    = '0;
    assign w_rs2_match    = '0;
    assign w_rs1_fwd_data = '0;
    assign w_rs2_fwd_data = '0;
    assign w_unused_fwd   = ^{fwd_valid, fwd_rd, fwd_data};
`endif

    logic w_rs1_fwd_hit;
    logic w_rs2_fwd_hit;
    logic w_rs1_wb_hit;
    logic w_rs2_wb_hit;

    assign w_rs1_fwd_hit = |w_rs1_match;
    assign w_rs2_fwd_hit = |w_rs2_match;
    assign w_rs1_wb_hit  = wb_valid & wb_rd[6] & (wb_rd[5:0] == w_rs1) & w_rs1_nz;
    assign w_rs2_wb_hit  = wb_valid & wb_rd[6] & (wb_rd[5:0] == w_rs2) & w_rs2_nz;

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_addr_sum;
    logic            w_unused_addr;

    assign w_rs1_val  = w_rs1_fwd_hit ? w_rs1_fwd_data :
                        w_rs1_wb_hit  ? wb_data        : rf_rs1data;
    assign w_rs2_val  = w_rs2_fwd_hit ? w_rs2_fwd_data :
                        w_rs2_wb_hit  ? wb_data        : rf_rs2data;
    assign w_op2      = w_op2_imm ? w_imm : w_rs2_val;
    assign w_addr_sum = w_rs1_val + w_imm;
    assign w_unused_addr = ^w_addr_sum[XLEN-1:30];

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic [63:0] r_busy;
    logic [63:0] w_busy_next;
    logic        r_out_valid;
    logic [6:0]  r_dec_rd;
    logic        w_rs1_stall;
    logic        w_rs2_stall;
    logic        w_waw;
    logic        w_hazard;
    logic        w_can_issue;
    logic        w_issue;

    assign w_rs1_stall = w_rs1_nz & r_busy[w_rs1] & ~w_rs1_fwd_hit & ~w_rs1_wb_hit;
    assign w_rs2_stall = w_rs2_used & w_rs2_nz & r_busy[w_rs2] &
                         ~w_rs2_fwd_hit & ~w_rs2_wb_hit;
    assign w_waw       = w_rd_wr & r_busy[w_rd[5:0]];
    assign w_hazard    = w_rs1_stall | w_rs2_stall | w_waw;
    assign w_can_issue = ~w_hazard & (~r_out_valid | out_ready) & ~flush;
    assign w_issue     = in_valid & w_can_issue;
    assign in_ready    = rst & w_can_issue;

    // Set is applied last so it wins over a same-cycle writeback clear.
    always_comb begin
        w_busy_next = r_busy;
        if (flush & r_out_valid & r_dec_rd[6]) w_busy_next[r_dec_rd[5:0]] = 1'b0;
        if (wb_valid)                          w_busy_next[wb_rd[5:0]]    = 1'b0;
        if (w_issue & w_rd_wr)                 w_busy_next[w_rd[5:0]]     = 1'b1;
    end

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic [6:0] w_branch;
    logic       w_mwe;
    logic       w_mre;

    always_comb begin
        w_branch = '0;
        for (int i = 0; i < 6; i++) begin
            w_branch[i] = (w_funct == 3'(i));
        end
        w_branch[6] = (w_op == 3'b110) & ~(&w_funct[2:1]);
    end

    assign w_mwe = (w_op == 3'b110) & (w_funct[2:1] == 2'b11);
    assign w_mre = (w_op == 3'b101) & (w_funct[2:1] == 2'b00);

    // ------------------------------------------------------------------
    // Output bundle register
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_dec_op1;
    logic [XLEN-1:0] r_dec_op2;
    logic [6:0]      r_aluctl;
    logic            r_dec_mre;
    logic            r_dec_mwe;
    logic [6:0]      r_dec_branch;
    logic [PCW-1:0]  r_dec_pc;
    logic [29:0]     r_daddr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy       <= '0;
            r_out_valid  <= 1'b0;
            r_dec_op1    <= '0;
            r_dec_op2    <= '0;
            r_aluctl     <= '0;
            r_dec_rd     <= '0;
            r_dec_mre    <= 1'b0;
            r_dec_mwe    <= 1'b0;
            r_dec_branch <= '0;
            r_dec_pc     <= '0;
            r_daddr      <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_issue) begin
                r_out_valid  <= 1'b1;
                r_dec_op1    <= w_rs1_val;
                r_dec_op2    <= w_op2;
                r_aluctl     <= {inst[11], w_op, w_funct};
                r_dec_rd     <= w_rd;
                r_dec_mre    <= w_mre;
                r_dec_mwe    <= w_mwe;
                r_dec_branch <= w_branch;
                r_dec_pc     <= pc;
                r_daddr      <= w_addr_sum[29:0];
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign dec_op1    = r_dec_op1;
    assign dec_op2    = r_dec_op2;
    assign aluctl     = r_aluctl;
    assign dec_rd     = r_dec_rd;
    assign dec_mre    = r_dec_mre;
    assign dec_mwe    = r_dec_mwe;
    assign dec_branch = r_dec_branch;
    assign dec_pc     = r_dec_pc;
    assign daddr      = r_daddr;

endmodule

`default_nettype wire
